// File: rtl/radix_lookup_table_pkg.sv
// Shared widths and constants for the radix-16 Booth digit recoder.
package radix_lookup_table_pkg;

  localparam int RADIX_W    = 5;
  localparam int DIGIT_W    = 4;
  localparam int CNT_W      = 4;
  localparam int OPND_W     = 33;
  localparam int NUM_DIGITS = 8;

  localparam logic [RADIX_W-1:0] ZERO_WIN = 5'b00000;

  typedef logic [RADIX_W-1:0] radix_t;

  // One recoded digit: sign plus magnitude 0..8.
  typedef struct packed {
    logic               sign;
    logic [DIGIT_W-1:0] mag;
  } booth_digit_t;

endpackage

// File: rtl/radix_lookup_table_if.sv
// Operand/digit bundle between the multiplier sequencer and the recoder.
interface radix_lookup_table_if;
  import radix_lookup_table_pkg::*;

  logic [CNT_W-1:0]   Count;
  logic [OPND_W-1:0]  B;
  logic               Sign;
  logic [DIGIT_W-1:0] Out;

  modport master (output Count, output B, input Sign, input Out);
  modport slave  (input Count, input B, output Sign, output Out);

endinterface

// File: rtl/radix_lookup_table_lut.sv
// Radix-16 Booth recoding table: 5-bit window -> sign + magnitude.
// Both all-zero and all-one windows map to +0 so downstream never sees -0.
module RadixLookUpTable
  import radix_lookup_table_pkg::*;
(
  input  radix_t             Radix,
  output logic               Sign,
  output logic [DIGIT_W-1:0] Out
);

  // Full 32-entry table; upper half mirrors the lower half with sign flipped.
  always_comb begin
    {Sign, Out} = 5'b0_0000;
    case (Radix)
      5'b00000: {Sign, Out} = {1'b0, 4'd0};
      5'b00001: {Sign, Out} = {1'b0, 4'd1};
      5'b00010: {Sign, Out} = {1'b0, 4'd1};
      5'b00011: {Sign, Out} = {1'b0, 4'd2};
      5'b00100: {Sign, Out} = {1'b0, 4'd2};
      5'b00101: {Sign, Out} = {1'b0, 4'd3};
      5'b00110: {Sign, Out} = {1'b0, 4'd3};
      5'b00111: {Sign, Out} = {1'b0, 4'd4};
      5'b01000: {Sign, Out} = {1'b0, 4'd4};
      5'b01001: {Sign, Out} = {1'b0, 4'd5};
      5'b01010: {Sign, Out} = {1'b0, 4'd5};
      5'b01011: {Sign, Out} = {1'b0, 4'd6};
      5'b01100: {Sign, Out} = {1'b0, 4'd6};
      5'b01101: {Sign, Out} = {1'b0, 4'd7};
      5'b01110: {Sign, Out} = {1'b0, 4'd7};
      5'b01111: {Sign, Out} = {1'b0, 4'd8};
      5'b10000: {Sign, Out} = {1'b1, 4'd8};
      5'b10001: {Sign, Out} = {1'b1, 4'd7};
      5'b10010: {Sign, Out} = {1'b1, 4'd7};
      5'b10011: {Sign, Out} = {1'b1, 4'd6};
      5'b10100: {Sign, Out} = {1'b1, 4'd6};
      5'b10101: {Sign, Out} = {1'b1, 4'd5};
      5'b10110: {Sign, Out} = {1'b1, 4'd5};
      5'b10111: {Sign, Out} = {1'b1, 4'd4};
      5'b11000: {Sign, Out} = {1'b1, 4'd4};
      5'b11001: {Sign, Out} = {1'b1, 4'd3};
      5'b11010: {Sign, Out} = {1'b1, 4'd3};
      5'b11011: {Sign, Out} = {1'b1, 4'd2};
      5'b11100: {Sign, Out} = {1'b1, 4'd2};
      5'b11101: {Sign, Out} = {1'b1, 4'd1};
      5'b11110: {Sign, Out} = {1'b1, 4'd1};
      5'b11111: {Sign, Out} = {1'b0, 4'd0};
      default:  {Sign, Out} = {1'b0, 4'd0};
    endcase
  end

endmodule

// File: rtl/radix_lookup_table_mux.sv
// 16-input, 5-bit wide combinational selector for the digit windows.
module Mux16to1_5bit
  import radix_lookup_table_pkg::*;
(
  input  radix_t           I0,
  input  radix_t           I1,
  input  radix_t           I2,
  input  radix_t           I3,
  input  radix_t           I4,
  input  radix_t           I5,
  input  radix_t           I6,
  input  radix_t           I7,
  input  radix_t           I8,
  input  radix_t           I9,
  input  radix_t           I10,
  input  radix_t           I11,
  input  radix_t           I12,
  input  radix_t           I13,
  input  radix_t           I14,
  input  radix_t           I15,
  input  logic [CNT_W-1:0] Sel,
  output radix_t           Y
);

  // Plain one-of-sixteen selection; every Sel value is covered.
  always_comb begin
    Y = I0;
    case (Sel)
      4'd0:  Y = I0;
      4'd1:  Y = I1;
      4'd2:  Y = I2;
      4'd3:  Y = I3;
      4'd4:  Y = I4;
      4'd5:  Y = I5;
      4'd6:  Y = I6;
      4'd7:  Y = I7;
      4'd8:  Y = I8;
      4'd9:  Y = I9;
      4'd10: Y = I10;
      4'd11: Y = I11;
      4'd12: Y = I12;
      4'd13: Y = I13;
      4'd14: Y = I14;
      4'd15: Y = I15;
      default: Y = I0;
    endcase
  end

endmodule

// File: rtl/radix_lookup_table.sv
// Booth digit recoder top: window select, table lookup, one output register.
module radix_lookup_table
  import radix_lookup_table_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  radix_lookup_table_if.slave bus
);

  radix_t       win [NUM_DIGITS];
  radix_t       radix;
  booth_digit_t digit;
  booth_digit_t digit_d;
  booth_digit_t digit_q;

  // Overlapping 5-bit windows stepping by 4 bits; neighbours share one bit.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_win
    assign win[k] = bus.B[4*k +: RADIX_W];
  end

  Mux16to1_5bit u_mux (
    .I0  (win[0]),
    .I1  (win[1]),
    .I2  (win[2]),
    .I3  (win[3]),
    .I4  (win[4]),
    .I5  (win[5]),
    .I6  (win[6]),
    .I7  (win[7]),
    .I8  (ZERO_WIN),
    .I9  (ZERO_WIN),
    .I10 (ZERO_WIN),
    .I11 (ZERO_WIN),
    .I12 (ZERO_WIN),
    .I13 (ZERO_WIN),
    .I14 (ZERO_WIN),
    .I15 (ZERO_WIN),
    .Sel (bus.Count),
    .Y   (radix)
  );

  RadixLookUpTable u_lut (
    .Radix (radix),
    .Sign  (digit.sign),
    .Out   (digit.mag)
  );

  // Next output is simply the current lookup; no other state is held.
  always_comb begin
    digit_d = digit;
  end

  // Output register, cleared synchronously while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign bus.Sign = digit_q.sign;
  assign bus.Out  = digit_q.mag;

endmodule

// File: tb/tb_radix_lookup_table.sv
// Scoreboard bench for the Booth digit recoder.
module tb_radix_lookup_table;

  logic clk;
  logic rst;

  radix_lookup_table_if bus ();

  radix_lookup_table dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] exp_q [$];
  string      name_q [$];
  int         n_cmp;
  int         n_bad;

  // Reference: Booth digit from the spec formula using signed arithmetic.
  function automatic logic [4:0] ref_digit(input logic [32:0] b, input logic [3:0] c);
    logic [4:0] w;
    int d;
    if (c >= 4'd8) w = 5'b00000;
    else w = 5'((b >> (4 * int'(c))) & 33'h1F);
    d = -8 * int'(w[4]) + 4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
    if (d < 0) return {1'b1, 4'(-d)};
    return {1'b0, 4'(d)};
  endfunction

  task automatic step(input logic r, input logic [3:0] c, input logic [32:0] b, input string nm);
    @(negedge clk);
    rst = r;
    bus.Count = c;
    bus.B = b;
    exp_q.push_back(r ? 5'b0_0000 : ref_digit(b, c));
    name_q.push_back(nm);
  endtask

  function automatic logic [32:0] rand_b();
    return {1'($urandom & 1), 32'($urandom)};
  endfunction

  // Monitor: one registered output per edge, compared against the queue head.
  initial begin
    logic [4:0] exp;
    logic [4:0] got;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm = name_q.pop_front();
        got = {bus.Sign, bus.Out};
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL %s: got sign=%0b out=%0d, expected sign=%0b out=%0d",
                   nm, got[4], got[3:0], exp[4], exp[3:0]);
        end
        n_cmp++;
        if (got[3:0] > 4'd8) begin
          n_bad++;
          $display("FAIL %s_range: got out=%0d, expected out<=8", nm, got[3:0]);
        end
      end
    end
  end

  initial begin
    logic [32:0] b;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.Count = 4'd0;
    bus.B = 33'h0;

    step(1'b1, 4'd0, 33'h1_FFFF_FFFF, "reset0");
    step(1'b1, 4'd0, 33'h1_FFFF_FFFF, "reset1");
    step(1'b0, 4'd0, 33'h1_FFFF_FFFF, "release_11111");

    step(1'b0, 4'd0, 33'h0_0000_0010, "neg8");
    step(1'b0, 4'd0, 33'h0_0000_000F, "pos8");
    step(1'b0, 4'd0, 33'h0_0000_0016, "neg5");
    step(1'b0, 4'd1, 33'h0_0000_0070, "overlap_c1");
    step(1'b0, 4'd0, 33'h0_0000_0070, "overlap_c0");
    step(1'b0, 4'd8, 33'h1_5A5A_5A5A, "count8");
    step(1'b0, 4'd12, 33'h1_5A5A_5A5A, "count12");

    for (int r = 0; r < 32; r++) begin
      b = {5'(r), 28'($urandom)};
      step(1'b0, 4'd7, b, $sformatf("table_%0d", r));
    end

    for (int s = 0; s < 6; s++) begin
      b = rand_b();
      for (int c = 0; c < 8; c++) step(1'b0, 4'(c), b, $sformatf("sweep%0d_c%0d", s, c));
    end

    b = rand_b();
    step(1'b0, 4'd3, b, "pre_midrst");
    step(1'b1, 4'd3, b, "midrst");
    step(1'b0, 4'd3, b, "post_midrst");

    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(19, 0) == 0), 4'($urandom_range(15, 0)), rand_b(), $sformatf("rand%0d", i));
    end

    step(1'b0, 4'd0, 33'h0, "tail");
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
